// File: rtl/pwm_multi_if.sv
// pwm_multi_if: duty-register write bus for pwm_multi.
//   wr_en   : write strobe for a channel's pending duty register
//   wr_ch   : channel select; values >= CHANNELS are ignored by the slave
//   wr_duty : duty value to write
// Modports: master (bus driver, e.g. MCU bridge), slave (pwm_multi).
interface pwm_multi_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [WIDTH-1:0] wr_duty;

  modport master (output wr_en, output wr_ch, output wr_duty);
  modport slave  (input  wr_en, input  wr_ch, input  wr_duty);
endinterface

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator sharing one period counter.
// Each channel has a pending duty register (written over the bus) and an
// active duty register that is only reloaded at a period boundary, so a
// write never produces a partial period.
//
// Ports:
//   clk         : system clock, all logic on posedge
//   rst         : synchronous active-high reset
//   enable      : run counter; low holds count at 0 and forces outputs low
//   period      : terminal count, loaded at each period boundary
//   center      : (only with PWM_CENTER_ALIGN_EN) up/down counting mode
//   bus         : pwm_multi_if.slave duty write bus
//   pwm_out     : registered PWM outputs, one per channel
//   period_tick : registered one-cycle pulse following each boundary
//
// Build option: define PWM_CENTER_ALIGN_EN to add center-aligned mode.
module pwm_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [WIDTH-1:0]    period,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic                center,
`endif
  pwm_multi_if.slave          bus,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [WIDTH-1:0]    count;
  logic [WIDTH-1:0]    count_nxt;
  logic [WIDTH-1:0]    period_act;
  logic [WIDTH-1:0]    duty_pend [CHANNELS];
  logic [WIDTH-1:0]    duty_act  [CHANNELS];
  logic                boundary;
  logic                load;
  logic                wr_ok;
  logic [CHANNELS-1:0] wr_hit;

`ifdef PWM_CENTER_ALIGN_EN
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;
  dir_t dir;
  dir_t dir_nxt;
  logic center_act;
`endif

  // Unsigned compare: duty 0 never fires, duty above the top count always fires.
  function automatic logic duty_cmp(input logic [WIDTH-1:0] cnt,
                                    input logic [WIDTH-1:0] duty);
    return cnt < duty;
  endfunction

  // Channel decode; out-of-range selects simply match nothing.
  always_comb begin
    wr_ok  = ({1'b0, bus.wr_ch} < (CH_W+1)'(CHANNELS));
    wr_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = bus.wr_en && wr_ok && (bus.wr_ch == CH_W'(i));
    end
  end

  // Counter next state and boundary detection
  always_comb begin
    boundary  = 1'b0;
    count_nxt = count;
`ifdef PWM_CENTER_ALIGN_EN
    dir_nxt   = dir;
    if (center_act) begin
      // Up 0..period_act, then down period_act-1..1; very short periods
      // degenerate to a boundary every cycle at count 0.
      boundary = ((dir == DIR_DOWN) && (count == WIDTH'(1))) ||
                 ((period_act <= WIDTH'(1)) && (count == '0));
      if (dir == DIR_UP && count == period_act) begin
        dir_nxt   = DIR_DOWN;
        count_nxt = count - 1'b1;
      end else if (dir == DIR_UP) begin
        count_nxt = count + 1'b1;
      end else begin
        count_nxt = count - 1'b1;
      end
    end else begin
      boundary  = (count == period_act);
      count_nxt = count + 1'b1;
    end
    if (!enable || boundary) begin
      count_nxt = '0;
      dir_nxt   = DIR_UP;
    end
`else
    boundary  = (count == period_act);
    count_nxt = count + 1'b1;
    if (!enable || boundary) begin
      count_nxt = '0;
    end
`endif
  end

  // While disabled the active registers track their sources every cycle,
  // so re-enabling starts a clean period with the latest settings.
  assign load = !enable || boundary;

`ifdef PWM_CENTER_ALIGN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dir <= DIR_UP;
    end else begin
      dir <= dir_nxt;
    end
  end
`endif

  // Counter, active/pending registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      period_act  <= '1;
      pwm_out     <= '0;
      period_tick <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      center_act  <= 1'b0;
`endif
      for (int i = 0; i < CHANNELS; i++) begin
        duty_pend[i] <= '0;
        duty_act[i]  <= '0;
      end
    end else begin
      count       <= count_nxt;
      period_tick <= enable && boundary;
      if (load) begin
        period_act <= period;
`ifdef PWM_CENTER_ALIGN_EN
        center_act <= center;
`endif
      end
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i] <= enable && duty_cmp(count, duty_act[i]);
        if (wr_hit[i]) begin
          duty_pend[i] <= bus.wr_duty;
        end
        // A write landing on a load cycle bypasses the pending register.
        if (load) begin
          duty_act[i] <= wr_hit[i] ? bus.wr_duty : duty_pend[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_multi.sv
// Testbench for pwm_multi (WIDTH=8, CHANNELS=3 so that wr_ch=3 is an
// out-of-range select). A period-position reference model runs every cycle;
// a vector table and directed sequences add hand-derived expectations.
module tb_pwm_multi;
  localparam int W  = 8;
  localparam int CH = 3;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [W-1:0]  period;
  logic [CH-1:0] pwm_out;
  logic          period_tick;
`ifdef PWM_CENTER_ALIGN_EN
  logic          center;
`endif

  pwm_multi_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

  pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .period      (period),
`ifdef PWM_CENTER_ALIGN_EN
    .center      (center),
`endif
    .bus         (bus),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position within the current period plus the
  // pending/active duty sets.
  int            m_pos;
  int            m_per;
  int            m_pend [CH];
  int            m_act  [CH];
  logic [CH-1:0] exp_pwm;
  logic          exp_tick;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step();
    logic bnd;
    if (rst) begin
      m_pos = 0;
      m_per = 255;
      for (int i = 0; i < CH; i++) begin
        m_pend[i] = 0;
        m_act[i]  = 0;
      end
      exp_pwm  = '0;
      exp_tick = 1'b0;
    end else begin
      bnd = (m_pos == m_per);
      for (int i = 0; i < CH; i++) exp_pwm[i] = enable && (m_pos < m_act[i]);
      exp_tick = enable && bnd;
      if (bus.wr_en && int'(bus.wr_ch) < CH) m_pend[bus.wr_ch] = int'(bus.wr_duty);
      if (!enable || bnd) begin
        m_per = int'(period);
        for (int i = 0; i < CH; i++) m_act[i] = m_pend[i];
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
  endtask

  // One clock: inputs already driven; advance model, compare after the edge.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("model_pwm_out", 32'(pwm_out), 32'(exp_pwm));
    check("model_period_tick", 32'(period_tick), 32'(exp_tick));
    bus.wr_en = 1'b0;
  endtask

  task automatic write(input int ch, input int duty);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 2'(ch);
    bus.wr_duty = W'(duty);
  endtask

  task automatic wait_tick(input int budget);
    int k;
    k = 0;
    while (period_tick !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    check("wait_tick_timeout", 32'(period_tick), 32'd1);
  endtask

  typedef struct {
    logic          en;
    logic [W-1:0]  per;
    logic          we;
    logic [1:0]    ch;
    logic [W-1:0]  duty;
    logic [CH-1:0] pwm;
    logic          tick;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int hi0, hi1, hi2, ticks;

    // Hand-derived vectors, starting from reset state (period_act 255, duties 0)
    tbl[0] = '{1'b0, 8'd0, 1'b1, 2'd0, 8'd1,   3'b000, 1'b0};
    tbl[1] = '{1'b0, 8'd0, 1'b1, 2'd1, 8'd0,   3'b000, 1'b0};
    tbl[2] = '{1'b1, 8'd0, 1'b0, 2'd0, 8'd0,   3'b001, 1'b1};
    tbl[3] = '{1'b1, 8'd0, 1'b1, 2'd2, 8'd5,   3'b001, 1'b1};
    tbl[4] = '{1'b1, 8'd0, 1'b1, 2'd3, 8'd7,   3'b101, 1'b1};
    tbl[5] = '{1'b1, 8'd2, 1'b0, 2'd0, 8'd0,   3'b101, 1'b1};
    tbl[6] = '{1'b1, 8'd2, 1'b0, 2'd0, 8'd0,   3'b101, 1'b0};
    tbl[7] = '{1'b1, 8'd2, 1'b0, 2'd0, 8'd0,   3'b100, 1'b0};
    tbl[8] = '{1'b1, 8'd2, 1'b0, 2'd0, 8'd0,   3'b100, 1'b1};
    tbl[9] = '{1'b0, 8'd2, 1'b0, 2'd0, 8'd0,   3'b000, 1'b0};

    rst = 1'b1; enable = 1'b0; period = 8'd9;
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_duty = '0;
`ifdef PWM_CENTER_ALIGN_EN
    center = 1'b0;
`endif
    #2;
    step(); step();
    check("reset_pwm_out", 32'(pwm_out), 32'd0);
    check("reset_tick", 32'(period_tick), 32'd0);
    rst = 1'b0;

    // Basic edge-aligned operation: duty 3 of period 10
    enable = 1'b1;
    write(0, 3);
    step();
    wait_tick(400);
    for (int rep = 0; rep < 2; rep++) begin
      hi0 = 0; ticks = 0;
      for (int k = 0; k < 10; k++) begin
        step();
        hi0 += int'(pwm_out[0]);
        ticks += int'(period_tick);
      end
      check("ch0_high_per_period", 32'(hi0), 32'd3);
      check("ticks_per_10", 32'(ticks), 32'd1);
    end

    // Duty 0 and duty above period
    write(1, 0); step();
    write(2, 12); step();
    wait_tick(20);
    hi1 = 0; hi2 = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      hi1 += int'(pwm_out[1]);
      hi2 += int'(pwm_out[2]);
    end
    check("ch1_duty0_const_low", 32'(hi1), 32'd0);
    check("ch2_duty12_const_high", 32'(hi2), 32'd20);

    // Mid-period write (count 5) vs boundary write-through (count 9)
    wait_tick(20);
    hi0 = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 5) write(0, 7);
      step();
      hi0 += int'(pwm_out[0]);
    end
    check("midwrite_current_period", 32'(hi0), 32'd3);
    hi0 = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 9) write(0, 2);
      step();
      hi0 += int'(pwm_out[0]);
    end
    check("midwrite_next_period", 32'(hi0), 32'd7);
    hi0 = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      hi0 += int'(pwm_out[0]);
    end
    check("boundary_write_through", 32'(hi0), 32'd2);

    // Period change mid-period (count 2) and out-of-range channel
    ticks = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) period = 8'd4;
      if (k == 5) write(3, 200);
      step();
      ticks += int'(period_tick);
    end
    check("period_change_deferred", 32'(ticks), 32'd1);
    ticks = 0; hi0 = 0; hi2 = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      ticks += int'(period_tick);
      hi0 += int'(pwm_out[0]);
      hi2 += int'(pwm_out[2]);
    end
    check("period5_ticks", 32'(ticks), 32'd3);
    check("period5_ch0_high", 32'(hi0), 32'd6);
    check("bad_channel_ignored_ch2", 32'(hi2), 32'd15);

    // Reset at count 6
    period = 8'd9;
    wait_tick(20);
    step();
    wait_tick(20);
    for (int k = 0; k < 6; k++) step();
    rst = 1'b1;
    step();
    check("rst_mid_pwm_out", 32'(pwm_out), 32'd0);
    check("rst_mid_tick", 32'(period_tick), 32'd0);
    rst = 1'b0;
    hi0 = 0; ticks = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      hi0 += int'(pwm_out != '0);
      ticks += int'(period_tick);
    end
    check("post_rst_outputs_low", 32'(hi0), 32'd0);
    check("post_rst_no_tick", 32'(ticks), 32'd0);

    // Vector table (period 0, disable tracking, write-through, bad channel)
    rst = 1'b1; step(); rst = 1'b0;
    for (int v = 0; v < 10; v++) begin
      enable = tbl[v].en;
      period = tbl[v].per;
      if (tbl[v].we) write(int'(tbl[v].ch), int'(tbl[v].duty));
      step();
      check($sformatf("tbl%0d_pwm_out", v), 32'(pwm_out), 32'(tbl[v].pwm));
      check($sformatf("tbl%0d_tick", v), 32'(period_tick), 32'(tbl[v].tick));
    end

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      enable = ($urandom % 16) != 0;
      if ($urandom % 32 == 0) period = W'($urandom % 16);
      if ($urandom % 4 == 0) write(int'($urandom % 4), int'($urandom % 20));
      rst = ($urandom % 500) == 0;
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
